// File: rtl/fft_mult_pkg.sv
// Shared types and constants for the FFT-stage multiplier and its users.
// Provides operand/product widths, the multiplier latency, and the tag
// record {vld, id} carried alongside each in-flight operation.
package fft_mult_pkg;

    localparam int unsigned MUL_W_IN  = 8;
    localparam int unsigned MUL_W_OUT = 16;
    localparam int unsigned MUL_LAT   = 8;

    // Wide enough for requester IDs of up to 8 requesters.
    localparam int unsigned TAG_ID_W  = 3;

    typedef struct packed {
        logic                vld;
        logic [TAG_ID_W-1:0] id;
    } tag_t;

endpackage

// File: rtl/mult_share_arb_if.sv
// Bus bundle for mult_share_arb.
//   requester side : req_valid, req_a, req_b, req_mask -> req_ready
//   multiplier side: mul_en, mul_a, mul_b -> mul_result, mul_rdy
//   response side  : rsp_valid, rsp_data
//   status         : inflight, idle, tag_err
// slave  = the arbiter; master = requesters + multiplier environment.
interface mult_share_arb_if #(
    parameter int unsigned N_REQ = 4
);
    localparam int unsigned W_IN  = fft_mult_pkg::MUL_W_IN;
    localparam int unsigned W_OUT = fft_mult_pkg::MUL_W_OUT;
    localparam int unsigned CNT_W = 4;

    logic [N_REQ-1:0]      req_valid;
    logic [W_IN*N_REQ-1:0] req_a;
    logic [W_IN*N_REQ-1:0] req_b;
    logic [N_REQ-1:0]      req_ready;
    logic [N_REQ-1:0]      req_mask;

    logic                  mul_en;
    logic [W_IN-1:0]       mul_a;
    logic [W_IN-1:0]       mul_b;
    logic [W_OUT-1:0]      mul_result;
    logic                  mul_rdy;

    logic [N_REQ-1:0]      rsp_valid;
    logic [W_OUT-1:0]      rsp_data;

    logic [CNT_W-1:0]      inflight;
    logic                  idle;
    logic                  tag_err;

    modport master (
        output req_valid, req_a, req_b, req_mask, mul_result, mul_rdy,
        input  req_ready, mul_en, mul_a, mul_b, rsp_valid, rsp_data,
               inflight, idle, tag_err
    );

    modport slave (
        input  req_valid, req_a, req_b, req_mask, mul_result, mul_rdy,
        output req_ready, mul_en, mul_a, mul_b, rsp_valid, rsp_data,
               inflight, idle, tag_err
    );

endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin selector, reusable for any shared resource.
//   eligible : per-requester eligibility
//   ptr      : highest-priority index this cycle (must be < N)
//   grant    : one-hot, first eligible index at or above ptr, wrapping
module rr_pick #(
    parameter int unsigned N    = 4,
    parameter int unsigned ID_W = 2
) (
    input  logic [N-1:0]    eligible,
    input  logic [ID_W-1:0] ptr,
    output logic [N-1:0]    grant
);

    logic [2*N-1:0] elig_dbl;
    logic [N-1:0]   rot;
    logic [N-1:0]   rot_gnt;
    logic [2*N-1:0] gnt_dbl;

    // Rotate so that bit k of rot is eligible[(ptr+k) mod N].
    assign elig_dbl = {eligible, eligible} >> ptr;
    assign rot      = elig_dbl[N-1:0];

    // Lowest set bit of the rotated vector is the winner.
    assign rot_gnt  = rot & (~rot + N'(1));

    // Rotate back and fold the wrapped half onto the low half.
    assign gnt_dbl  = {N'(0), rot_gnt} << ptr;
    assign grant    = gnt_dbl[N-1:0] | gnt_dbl[2*N-1:N];

endmodule

// File: rtl/mult_share_arb.sv
// Round-robin arbiter/sequencer sharing one pipelined 8x8 multiplier among
// N_REQ requesters. Grants one requester per cycle, registers the operands
// into the multiplier, tags each issue with the requester ID in a delay line
// aligned to the multiplier latency, and routes returning products back.
//   clk, rst : clock, synchronous active-high reset
//   bus      : mult_share_arb_if.slave (requests, multiplier, responses,
//              inflight/idle/tag_err status)
module mult_share_arb #(
    parameter int unsigned N_REQ   = 4,
    parameter int unsigned MUL_LAT = fft_mult_pkg::MUL_LAT,
    parameter int unsigned ID_W    = 2
) (
    input  logic              clk,
    input  logic              rst,
    mult_share_arb_if.slave   bus
);

    localparam int unsigned W_IN     = fft_mult_pkg::MUL_W_IN;
    localparam int unsigned W_OUT    = fft_mult_pkg::MUL_W_OUT;
    localparam int unsigned TAG_ID_W = fft_mult_pkg::TAG_ID_W;
    localparam int unsigned N_STG    = MUL_LAT + 1;
    localparam int unsigned CNT_W    = 4;

    typedef fft_mult_pkg::tag_t tag_t;

    logic [N_REQ-1:0] eligible;
    logic [N_REQ-1:0] grant;
    logic [N_REQ-1:0] ready;
    logic             xfer;
    logic [ID_W-1:0]  gnt_id;
    logic [ID_W-1:0]  ptr_q;
    logic [ID_W-1:0]  ptr_nxt;
    logic [W_IN-1:0]  sel_a;
    logic [W_IN-1:0]  sel_b;

    logic             mul_en_q;
    logic [W_IN-1:0]  mul_a_q;
    logic [W_IN-1:0]  mul_b_q;

    tag_t             tags_q [N_STG];
    tag_t             tag_in;
    tag_t             tail;

    logic [N_REQ-1:0] rsp_hit;
    logic [N_REQ-1:0] rsp_valid_q;
    logic [W_OUT-1:0] rsp_data_q;
    logic [CNT_W-1:0] inflight_q;
    logic             tag_err_q;

    // Arbitration
    assign eligible = bus.req_valid & bus.req_mask;

    rr_pick #(
        .N    (N_REQ),
        .ID_W (ID_W)
    ) u_pick (
        .eligible (eligible),
        .ptr      (ptr_q),
        .grant    (grant)
    );

    assign ready = rst ? '0 : grant;
    assign xfer  = |ready;

    // Encode the one-hot grant and mux the winner's operands.
    always_comb begin
        gnt_id = '0;
        sel_a  = '0;
        sel_b  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (ready[i]) begin
                gnt_id = ID_W'(i);
                sel_a  = bus.req_a[W_IN*i +: W_IN];
                sel_b  = bus.req_b[W_IN*i +: W_IN];
            end
        end
    end

    assign ptr_nxt = (gnt_id == ID_W'(N_REQ - 1)) ? '0 : gnt_id + ID_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else if (xfer) begin
            ptr_q <= ptr_nxt;
        end
    end

    // Issue register into the multiplier; operands hold on idle cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            mul_en_q <= 1'b0;
            mul_a_q  <= '0;
            mul_b_q  <= '0;
        end else begin
            mul_en_q <= xfer;
            if (xfer) begin
                mul_a_q <= sel_a;
                mul_b_q <= sel_b;
            end
        end
    end

    // Tag delay line: the tail stage lines up with mul_rdy of the same issue.
    always_comb begin
        tag_in     = '0;
        tag_in.vld = xfer;
        tag_in.id  = TAG_ID_W'(gnt_id);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < N_STG; s++) begin
                tags_q[s] <= '0;
            end
        end else begin
            tags_q[0] <= tag_in;
            for (int s = 1; s < N_STG; s++) begin
                tags_q[s] <= tags_q[s-1];
            end
        end
    end

    assign tail = tags_q[N_STG-1];

    // A product is delivered only when both the strobe and a valid tag agree.
    always_comb begin
        rsp_hit = '0;
        for (int i = 0; i < N_REQ; i++) begin
            rsp_hit[i] = bus.mul_rdy && tail.vld && (tail.id == TAG_ID_W'(i));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
        end else begin
            rsp_valid_q <= rsp_hit;
            if (|rsp_hit) begin
                rsp_data_q <= bus.mul_result;
            end
        end
    end

    // Sticky misalignment flag: strobe without tag, or tag without strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            tag_err_q <= 1'b0;
        end else if (bus.mul_rdy != tail.vld) begin
            tag_err_q <= 1'b1;
        end
    end

    // Occupancy: an operation retires when its tag leaves the tail.
    always_ff @(posedge clk) begin
        if (rst) begin
            inflight_q <= '0;
        end else begin
            case ({xfer, tail.vld})
                2'b10:   inflight_q <= inflight_q + CNT_W'(1);
                2'b01:   inflight_q <= inflight_q - CNT_W'(1);
                default: inflight_q <= inflight_q;
            endcase
        end
    end

    assign bus.req_ready = ready;
    assign bus.mul_en    = mul_en_q;
    assign bus.mul_a     = mul_a_q;
    assign bus.mul_b     = mul_b_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.inflight  = inflight_q;
    assign bus.idle      = (inflight_q == '0) && !(|bus.req_valid);
    assign bus.tag_err   = tag_err_q;

endmodule

// File: tb/tb_mult_share_arb.sv
// Testbench for mult_share_arb: pipelined multiplier model, queue-based
// reference model checked every cycle, a table of grant vectors, and
// hand-written sequences for latency, load, mask, reset and fault cases.
module tb_mult_share_arb;

    localparam int unsigned N   = 4;
    localparam int unsigned LAT = 8;

    logic clk = 1'b0;
    logic rst;
    logic spur;

    always #5 clk = ~clk;

    mult_share_arb_if #(.N_REQ(N)) bus ();

    mult_share_arb #(
        .N_REQ   (N),
        .MUL_LAT (LAT),
        .ID_W    (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Multiplier: LAT-stage pipeline, reset together with the arbiter.
    logic        pv [LAT];
    logic [15:0] pp [LAT];

    always @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < LAT; s++) begin
                pv[s] <= 1'b0;
                pp[s] <= '0;
            end
        end else begin
            pv[0] <= bus.mul_en;
            pp[0] <= 16'(bus.mul_a) * 16'(bus.mul_b);
            for (int s = 1; s < LAT; s++) begin
                pv[s] <= pv[s-1];
                pp[s] <= pp[s-1];
            end
        end
    end

    assign bus.mul_rdy    = pv[LAT-1] | spur;
    assign bus.mul_result = spur ? 16'hDEAD : pp[LAT-1];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: pending responses in issue order with due cycle.
    typedef struct {
        int          id;
        logic [15:0] prod;
        int          due;
    } exp_rsp_t;

    exp_rsp_t    q[$];
    int          m_ptr  = 0;
    logic        m_en   = 1'b0;
    logic [7:0]  m_a    = '0;
    logic [7:0]  m_b    = '0;
    logic        m_err  = 1'b0;
    bit          mon_en = 1'b0;
    logic [N-1:0] mg;
    int          gi;
    bit          mfound;
    exp_rsp_t    ent;

    always @(negedge clk) begin
        if (mon_en) begin
            mg     = '0;
            gi     = 0;
            mfound = 1'b0;
            if (!rst) begin
                for (int k = 0; k < N; k++) begin
                    if (!mfound && bus.req_valid[(m_ptr + k) % N] && bus.req_mask[(m_ptr + k) % N]) begin
                        mfound = 1'b1;
                        gi     = (m_ptr + k) % N;
                        mg[gi] = 1'b1;
                    end
                end
            end
            check("mon grant", 32'(bus.req_ready), 32'(mg));
            check("mon mul_en", 32'(bus.mul_en), 32'(m_en));
            check("mon mul_a", 32'(bus.mul_a), 32'(m_a));
            check("mon mul_b", 32'(bus.mul_b), 32'(m_b));
            if (q.size() > 0 && q[0].due == cyc) begin
                check("mon rsp_valid", 32'(bus.rsp_valid), 32'(1) << q[0].id);
                check("mon rsp_data", 32'(bus.rsp_data), 32'(q[0].prod));
                q.delete(0);
            end else begin
                check("mon rsp_idle", 32'(bus.rsp_valid), 32'(0));
            end
            check("mon tag_err", 32'(bus.tag_err), 32'(m_err));
            check("mon inflight", 32'(bus.inflight), 32'(q.size()));
            check("mon idle", 32'(bus.idle), 32'((q.size() == 0) && (bus.req_valid == '0)));
            if (spur) m_err = 1'b1;
            if (mfound) begin
                ent.id   = gi;
                ent.prod = 16'(bus.req_a[8*gi +: 8]) * 16'(bus.req_b[8*gi +: 8]);
                ent.due  = cyc + 2 + LAT;
                q.push_back(ent);
                m_ptr = (gi + 1) % N;
                m_en  = 1'b1;
                m_a   = bus.req_a[8*gi +: 8];
                m_b   = bus.req_b[8*gi +: 8];
            end else begin
                m_en = 1'b0;
            end
            if (rst) begin
                q.delete();
                m_ptr = 0;
                m_en  = 1'b0;
                m_a   = '0;
                m_b   = '0;
                m_err = 1'b0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [7:0] a, input logic [7:0] b);
        bus.req_a[8*i +: 8] = a;
        bus.req_b[8*i +: 8] = b;
    endtask

    task automatic refresh(input logic [N-1:0] g);
        for (int i = 0; i < N; i++) begin
            if (g[i]) set_req(i, 8'($urandom), 8'($urandom));
        end
    endtask

    task automatic do_reset();
        bus.req_valid = '0;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    typedef struct {
        logic [3:0]  valid;
        logic [3:0]  mask;
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  ready;
    } vec_t;

    vec_t tbl [10];

    initial begin
        #500000;
        $display("FAIL global timeout at cycle %0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        logic [N-1:0] g;
        int  t0;
        int  cnt;
        int  first_c;
        int  last_c;
        int  maxinf;
        bit  found;
        bit  seen0;
        int  exp_seq [6];

        rst           = 1'b1;
        spur          = 1'b0;
        bus.req_valid = '0;
        bus.req_mask  = '1;
        bus.req_a     = '0;
        bus.req_b     = '0;
        tick();
        tick();
        tick();
        rst    = 1'b0;
        mon_en = 1'b1;

        // Reset state
        check("reset mul_en", 32'(bus.mul_en), 0);
        check("reset inflight", 32'(bus.inflight), 0);
        check("reset tag_err", 32'(bus.tag_err), 0);
        check("reset rsp_valid", 32'(bus.rsp_valid), 0);
        check("reset idle", 32'(bus.idle), 1);

        // Grant table, applied in order starting from ptr=0
        tbl[0] = '{4'b0000, 4'b1111, 32'h01020304, 32'h05060708, 4'b0000};
        tbl[1] = '{4'b0010, 4'b1111, 32'h01020304, 32'h05060708, 4'b0010};
        tbl[2] = '{4'b1111, 4'b1111, 32'h0A0B0C0D, 32'h11121314, 4'b0100};
        tbl[3] = '{4'b0011, 4'b1111, 32'h0A0B0C0D, 32'h11121314, 4'b0001};
        tbl[4] = '{4'b1111, 4'b1011, 32'hFF10FF20, 32'h02030405, 4'b0010};
        tbl[5] = '{4'b1111, 4'b1011, 32'hFF10FF20, 32'h02030405, 4'b1000};
        tbl[6] = '{4'b0100, 4'b1011, 32'h33333333, 32'h44444444, 4'b0000};
        tbl[7] = '{4'b1000, 4'b1111, 32'h80000000, 32'h80000000, 4'b1000};
        tbl[8] = '{4'b1001, 4'b1111, 32'h90000007, 32'h20000009, 4'b0001};
        tbl[9] = '{4'b1001, 4'b1111, 32'h90000007, 32'h20000009, 4'b1000};
        for (int v = 0; v < 10; v++) begin
            bus.req_valid = tbl[v].valid;
            bus.req_mask  = tbl[v].mask;
            bus.req_a     = tbl[v].a;
            bus.req_b     = tbl[v].b;
            #1;
            check($sformatf("vec%0d ready", v), 32'(bus.req_ready), 32'(tbl[v].ready));
            tick();
        end
        bus.req_valid = '0;
        bus.req_mask  = '1;
        repeat (12) tick();

        // Single request: 13*11 at t+10
        do_reset();
        set_req(1, 8'd13, 8'd11);
        bus.req_valid = 4'b0010;
        #1;
        check("single ready", 32'(bus.req_ready), 32'h2);
        t0 = cyc;
        tick();
        bus.req_valid = '0;
        check("single mul_en", 32'(bus.mul_en), 1);
        check("single mul_a", 32'(bus.mul_a), 13);
        found = 1'b0;
        for (int w = 0; w < 20 && !found; w++) begin
            if (bus.rsp_valid != '0) begin
                found = 1'b1;
                check("single latency", 32'(cyc - t0), 10);
                check("single rsp_valid", 32'(bus.rsp_valid), 32'h2);
                check("single rsp_data", 32'(bus.rsp_data), 143);
            end else begin
                tick();
            end
        end
        check("single seen", 32'(found), 1);
        tick();

        // Reset mid-flight after 5 issues
        bus.req_valid = '1;
        for (int k = 0; k < 5; k++) begin
            #1;
            g = bus.req_ready;
            tick();
            refresh(g);
        end
        rst = 1'b1;
        #1;
        check("rst ready", 32'(bus.req_ready), 0);
        tick();
        rst = 1'b0;
        bus.req_valid = '0;
        check("rst inflight", 32'(bus.inflight), 0);
        check("rst mul_en", 32'(bus.mul_en), 0);
        check("rst mul_a", 32'(bus.mul_a), 0);
        check("rst mul_b", 32'(bus.mul_b), 0);
        check("rst rsp_valid", 32'(bus.rsp_valid), 0);
        check("rst rsp_data", 32'(bus.rsp_data), 0);
        check("rst tag_err", 32'(bus.tag_err), 0);
        cnt = 0;
        for (int w = 0; w < 16; w++) begin
            tick();
            if (bus.rsp_valid != '0) cnt++;
        end
        check("rst no rsp", 32'(cnt), 0);
        check("rst inflight end", 32'(bus.inflight), 0);

        // Full load: rotation and inflight saturation
        do_reset();
        set_req(0, 8'd255, 8'd255);
        for (int i = 1; i < N; i++) set_req(i, 8'(i * 17 + 3), 8'(i * 29 + 1));
        bus.req_valid = '1;
        maxinf = 0;
        seen0  = 1'b0;
        for (int k = 0; k < 12; k++) begin
            #1;
            g = bus.req_ready;
            check($sformatf("load grant%0d", k), 32'(g), 32'(1) << (k % N));
            tick();
            refresh(g);
            if (int'(bus.inflight) > maxinf) maxinf = int'(bus.inflight);
            if (!seen0 && bus.rsp_valid == 4'b0001) begin
                seen0 = 1'b1;
                check("load 255*255", 32'(bus.rsp_data), 32'hFE01);
            end
        end
        bus.req_valid = '0;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (int'(bus.inflight) > maxinf) maxinf = int'(bus.inflight);
        end
        check("load inflight max", 32'(maxinf), 9);
        check("load first rsp0", 32'(seen0), 1);

        // Mask requester 2
        do_reset();
        bus.req_mask  = 4'b1011;
        bus.req_valid = '1;
        exp_seq = '{0, 1, 3, 0, 1, 3};
        for (int k = 0; k < 6; k++) begin
            #1;
            g = bus.req_ready;
            check($sformatf("mask grant%0d", k), 32'(g), 32'(1) << exp_seq[k]);
            tick();
            refresh(g);
        end
        bus.req_valid = '0;
        bus.req_mask  = '1;
        repeat (12) tick();

        // Spurious mul_rdy with an empty tag line
        do_reset();
        spur = 1'b1;
        tick();
        spur = 1'b0;
        check("fault tag_err", 32'(bus.tag_err), 1);
        check("fault no rsp", 32'(bus.rsp_valid), 0);
        set_req(0, 8'd7, 8'd9);
        bus.req_valid = 4'b0001;
        tick();
        bus.req_valid = '0;
        found = 1'b0;
        for (int w = 0; w < 20 && !found; w++) begin
            if (bus.rsp_valid != '0) begin
                found = 1'b1;
                check("fault rsp_valid", 32'(bus.rsp_valid), 32'h1);
                check("fault rsp_data", 32'(bus.rsp_data), 63);
            end else begin
                tick();
            end
        end
        check("fault served", 32'(found), 1);
        check("fault sticky", 32'(bus.tag_err), 1);

        // Back-to-back requester 1
        do_reset();
        bus.req_valid = 4'b0010;
        for (int k = 0; k < 6; k++) begin
            set_req(1, 8'($urandom), 8'($urandom));
            #1;
            check($sformatf("b2b grant%0d", k), 32'(bus.req_ready), 32'h2);
            tick();
        end
        bus.req_valid = '0;
        cnt     = 0;
        first_c = -1;
        last_c  = -1;
        for (int w = 0; w < 20; w++) begin
            if (bus.rsp_valid == 4'b0010) begin
                cnt++;
                if (first_c < 0) first_c = cyc;
                last_c = cyc;
            end
            tick();
        end
        check("b2b rsp count", 32'(cnt), 6);
        check("b2b rsp span", 32'(last_c - first_c), 5);

        // Randomized traffic with random masking
        do_reset();
        for (int k = 0; k < 300; k++) begin
            for (int i = 0; i < N; i++) begin
                if (!bus.req_valid[i] && $urandom_range(0, 2) == 0) begin
                    bus.req_valid[i] = 1'b1;
                    set_req(i, 8'($urandom), 8'($urandom));
                end
            end
            bus.req_mask = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b1111;
            #1;
            g = bus.req_ready;
            tick();
            for (int i = 0; i < N; i++) begin
                if (g[i]) begin
                    if ($urandom_range(0, 1) == 0) bus.req_valid[i] = 1'b0;
                    else set_req(i, 8'($urandom), 8'($urandom));
                end
            end
        end
        bus.req_valid = '0;
        bus.req_mask  = '1;
        repeat (14) tick();
        check("drain queue", 32'(q.size()), 0);
        check("drain idle", 32'(bus.idle), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mult_share_arb.md
# mult_share_arb

Round-robin arbiter and sequencer that shares one 8-stage pipelined shift-add multiplier (8x8 → 16, one issue per cycle, fixed latency) among N_REQ requesters in the FFT stage. It accepts operand pairs over per-requester valid/ready handshakes and issues at most one product per cycle. It tags each issue with its requester ID in a delay line aligned to the multiplier latency, then routes each returning product to the requester that issued it. It also reports occupancy and checks tag/result alignment.

## Interface
Parameters:
- N_REQ, 4, number of requesters (2..8)
- MUL_LAT, 8, multiplier latency in cycles from mul_en to mul_rdy
- ID_W, 2, requester-ID width, equal to clog2(N_REQ)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset. Top level drives the multiplier reset as rst_n = ~rst, so both clear on the same edge.
- req_valid  in  N_REQ  per-requester request
- req_a  in  8*N_REQ  multiplicand, requester i at [8i+7:8i]
- req_b  in  8*N_REQ  multiplier, requester i at [8i+7:8i]
- req_ready  out  N_REQ  one-hot grant, combinational
- req_mask  in  N_REQ  1 = requester i is eligible for grant
- mul_en  out  1  issue strobe to the multiplier
- mul_a, mul_b  out  8 each  operands to the multiplier
- mul_result  in  16  product from the multiplier
- mul_rdy  in  1  product-valid strobe from the multiplier
- rsp_valid  out  N_REQ  one-hot, one-cycle pulse to the owning requester
- rsp_data  out  16  product, shared bus
- inflight  out  4  count of issued-but-unreturned operations (0..MUL_LAT+1)
- idle  out  1  high when inflight==0 and no req_valid is pending
- tag_err  out  1  sticky alignment error

## Operation
- Eligibility: requester i is eligible when req_valid[i] & req_mask[i].
- Grant: req_ready has at most one bit set. The selected requester is the first eligible one at or after ptr, searching upward and wrapping.
- A transfer completes on a cycle where req_valid[i] & req_ready[i] is high. The requester must hold its operands stable until then.
- ptr update: after a transfer by requester i, ptr becomes (i+1) mod N_REQ. Otherwise ptr holds. Reset value is 0.
- Issue register: a transfer loads mul_a/mul_b from the granted requester's operands and sets mul_en=1 on the next edge. A cycle with no transfer gives mul_en=0; mul_a/mul_b hold their values.
- Tag delay line: MUL_LAT+1 stages of {valid, ID}, written on every cycle from the transfer {1, i} or {0, x}. Stage alignment is fixed so the last stage coincides with mul_rdy for the same operation.
- Response: on mul_rdy with the tail tag valid, rsp_valid[tail ID]=1 and rsp_data=mul_result on the next edge. Both are registered.
- Alignment check: tag_err is set when mul_rdy and the tail tag valid differ on any cycle. On mul_rdy=1 with an invalid tag, the product is dropped and no rsp_valid is produced. tag_err clears only on rst.
- inflight: +1 on transfer, −1 on a valid tail tag. Both on the same cycle leaves it unchanged.
- Reset values: req_ready=0 during rst; mul_en=0; mul_a=0; mul_b=0; all tags invalid; rsp_valid=0; rsp_data=0; inflight=0; tag_err=0; ptr=0.
- Reset mid-operation: all in-flight operations are discarded; no responses are delivered for them.

## Timing
- Grant is combinational in the same cycle as req_valid. This is a single arbitration level with no path from req_ready back to req_valid inside the block.
- Throughput is one transfer per cycle. With every requester valid and unmasked, grants rotate 0,1,…,N_REQ−1,0 on consecutive cycles.
- Latency: transfer at edge t → mul_en high in cycle t+1 → mul_rdy in cycle t+1+MUL_LAT → rsp_valid high in cycle t+2+MUL_LAT.
- req_mask is sampled each cycle. Masking a requester while it is valid removes it from arbitration immediately and does not affect its in-flight operations.
- Responses return in issue order; there is no reordering.

## Structure
- Shared package `fft_mult_pkg`:
  - localparam MUL_W_IN=8, MUL_W_OUT=16, MUL_LAT=8
  - typedef tag_t {logic vld; logic [ID_W-1:0] id;}
- Sub-module `rr_pick`: combinational round-robin selector, inputs eligible and ptr, output one-hot grant. It is reusable for other shared FFT resources.
- The multiplier itself is outside this block and wired at the FFT stage top.

## Test plan
- Single request: req_valid=4'b0010 with a=8'd13, b=8'd11. Expect req_ready=4'b0010 the same cycle, mul_en one cycle later, and rsp_valid=4'b0010 with rsp_data=16'd143 at t+10.
- Full load: all four valid with distinct operands for 12 cycles. Expect grant order 0,1,2,3,0,1,2,3,…. Every product returns to its issuer in order with a correct value (check 255*255=16'hFE01), and inflight saturates at 9.
- Mask: req_mask=4'b1011 with all four valid. Expect requester 2 never granted and rotation 0,1,3,0,1,3.
- Reset mid-flight: issue 5 operations, then assert rst for 1 cycle. Expect all outputs at reset values, no rsp_valid afterwards, and inflight=0.
- Alignment fault: force a spurious mul_rdy with an empty tag line. Expect tag_err=1 sticky, no rsp_valid, and normal traffic still served.
- Back-to-back same requester: only requester 1 valid for 6 cycles. Expect 6 consecutive grants to requester 1 and 6 consecutive rsp_valid pulses to requester 1.
